rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among eight requesters. It grants exactly one requester at a time. The grant is presented both as a one-hot vector and as its 3-bit binary index, following the one-hot to 3-bit mapping the team's 8:3 encoder uses (bit k maps to index k). A grant holds until the owner signals completion, drops its request, or exceeds a programmable hold limit.

## Interface
- MAX_HOLD, default 16: maximum cycles a grant may be held before forced release. Legal range is 2..256.
- CNT_W, default 8: width of the hold counter. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- req_in, input, 8: request lines. Bit k is requester k, active-high, level-sensitive.
- done_in, input, 1: current owner finished. Sampled only in BUSY.
- grant_out, output, 8: one-hot grant. All zeros when no grant.
- grant_idx_out, output, 3: binary index of the granted bit. 3'd0 when no grant.
- grant_valid_out, output, 1: high while a grant is active.
- timeout_out, output, 1: one-cycle pulse on forced release.

## Operation
- Reset values:
  - grant_out = 8'h00, grant_idx_out = 3'd0, grant_valid_out = 0, timeout_out = 0.
  - state = IDLE, hold counter = 0.
  - Priority pointer last_idx = 3'd7, so requester 0 has top priority after reset.
- States: IDLE and BUSY. All outputs are registered.
- IDLE:
  - If req_in == 0, stay in IDLE.
  - Otherwise, select the first set bit of req_in scanning upward from (last_idx+1) mod 8, wrapping 7 to 0.
  - At the next edge: load grant_out with that one-hot bit, load grant_idx_out with its index, set grant_valid_out = 1, clear the counter, and go to BUSY.
- BUSY:
  - The grant is held constant.
  - The counter increments each cycle, saturating at MAX_HOLD-1.
  - Release when any of these hold at a sampled edge:
    - (a) done_in = 1.
    - (b) req_in[grant_idx_out] = 0.
    - (c) counter == MAX_HOLD-1.
  - On release, at the next edge:
    - grant_out = 0, grant_idx_out = 0, grant_valid_out = 0.
    - last_idx = the released index.
    - state = IDLE.
  - timeout_out = 1 for that single cycle only if (c) holds and neither (a) nor (b) holds.
- Fairness: a requester that just released has the lowest priority in the next arbitration. Any continuously requesting client is granted within 7 grant periods.
- Changes to req_in of non-owners during BUSY have no effect on the current grant.
- grant_idx_out always equals the encoding of grant_out. grant_out is never multi-hot.

## Timing
- Request-to-grant latency: req_in is sampled high in IDLE at edge N, and grant_valid_out is high after edge N (1 cycle).
- Release latency: the release condition is sampled at edge M, and grant_valid_out is low after edge M.
- At least one IDLE cycle separates consecutive grants. The minimum grant period is 2 cycles: 1 BUSY cycle plus 1 IDLE cycle.
- Forced-release timing: grant_valid_out is high for exactly MAX_HOLD cycles. The counter reads 0..MAX_HOLD-1, and the grant drops at the edge where the counter reads MAX_HOLD-1.
- Simultaneous events:
  - done_in together with timeout is treated as done, with no pulse.
  - done_in together with a request drop is a single release.
- done_in asserted in IDLE is ignored.
- Reset mid-grant: when rst asserts, all outputs go to their reset values immediately (asynchronously) and last_idx returns to 7.
- Reset release: the first arbitration occurs on the first edge after rst deasserts.

## Test plan
- Reset then single request: after rst, req_in = 8'h10. Expect grant_out = 8'h10, grant_idx_out = 4, and grant_valid_out = 1 one cycle later.
- Round-robin rotation: req_in = 8'hFF held, with done_in pulsed one cycle after each grant. Expect grant indices 0,1,2,...,7,0 in order, with one idle cycle between each.
- Wrap-around priority: after a grant to 6 is released, req_in = 8'h41. Expect a grant to 0, not 6. Then release and hold req_in = 8'h41. Expect a grant to 6.
- Timeout: MAX_HOLD = 4, req_in = 8'h02 held, done_in = 0.
  - Expect grant_valid_out high for exactly 4 cycles.
  - Expect timeout_out = 1 for 1 cycle coincident with the release.
  - Expect a re-grant to 1 after one IDLE cycle.
- Simultaneous release: done_in = 1 in the same cycle the counter reaches MAX_HOLD-1. Expect release with timeout_out = 0. Request drop alone: expect release with timeout_out = 0.
- Reset mid-grant: assert rst asynchronously while a grant to 5 is active. Expect all outputs to be 0 immediately. After rst deasserts with req_in = 8'hA0, expect a grant to 5.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_8_if
// Brief   : Request/grant bundle between requesters and the 8-way arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rr_arbiter_8_if;
  logic [7:0] req_in;
  logic       done_in;
  logic [7:0] grant_out;
  logic [2:0] grant_idx_out;
  logic       grant_valid_out;
  logic       timeout_out;

  modport master (
    output req_in,
    output done_in,
    input  grant_out,
    input  grant_idx_out,
    input  grant_valid_out,
    input  timeout_out
  );

  modport slave (
    input  req_in,
    input  done_in,
    output grant_out,
    output grant_idx_out,
    output grant_valid_out,
    output timeout_out
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_8
// Brief   : Eight-way round-robin arbiter with done/drop/hold-limit release.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rr_arbiter_8_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_grant;
  logic [2:0]       r_idx;
  logic             r_valid;
  logic             r_timeout;
  logic [2:0]       r_last_idx;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_pick_idx;
  logic [2:0]       w_cand;
  logic             w_req_any;
  logic             w_done;
  logic             w_drop;
  logic             w_hold_max;
  logic             w_release;

  // Scan from the lowest priority (last_idx itself) up to the highest
  // (last_idx+1) so the last hit written is the winner.
  always_comb begin
    w_pick_idx = 3'd0;
    w_cand     = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      w_cand = r_last_idx + i[2:0];
      if (bus.req_in[w_cand]) begin
        w_pick_idx = w_cand;
      end
    end
  end

  assign w_req_any  = |bus.req_in;
  assign w_done     = bus.done_in;
  assign w_drop     = ~bus.req_in[r_idx];
  assign w_hold_max = (r_cnt == c_cnt_last);
  assign w_release  = w_done | w_drop | w_hold_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= 8'h00;
      r_idx      <= 3'd0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_last_idx <= 3'd7;
      r_cnt      <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant <= 8'd1 << w_pick_idx;
            r_idx   <= w_pick_idx;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_grant    <= 8'h00;
            r_idx      <= 3'd0;
            r_valid    <= 1'b0;
            r_last_idx <= r_idx;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
            // Only a pure hold-limit expiry is reported as a timeout.
            r_timeout  <= w_hold_max & ~w_done & ~w_drop;
          end else if (!w_hold_max) begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_out       = r_grant;
  assign bus.grant_idx_out   = r_idx;
  assign bus.grant_valid_out = r_valid;
  assign bus.timeout_out     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
//------------------------------------------------------------------------------
// Module  : tb_rr_arbiter_8
// Brief   : Directed self-checking bench for rr_arbiter_8 (MAX_HOLD = 4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter_8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(
    .MAX_HOLD (4),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus.req_in  = 8'h00;
    bus.done_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bus.grant_out !== 8'h00) begin bad++; $display("FAIL reset_grant: got %h want %h", bus.grant_out, 8'h00); end
    total++; if (bus.grant_idx_out !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want %0d", bus.grant_idx_out, 0); end
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want %b", bus.grant_valid_out, 1'b0); end
    total++; if (bus.timeout_out !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want %b", bus.timeout_out, 1'b0); end
  endtask

  task automatic test_single();
    bus.req_in = 8'h10;
    tick();
    total++; if (bus.grant_out !== 8'h10) begin bad++; $display("FAIL single_grant: got %h want %h", bus.grant_out, 8'h10); end
    total++; if (bus.grant_idx_out !== 3'd4) begin bad++; $display("FAIL single_idx: got %0d want %0d", bus.grant_idx_out, 4); end
    total++; if (bus.grant_valid_out !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want %b", bus.grant_valid_out, 1'b1); end
    bus.req_in = 8'h00;
    tick();
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL single_drop_valid: got %b want %b", bus.grant_valid_out, 1'b0); end
    total++; if (bus.timeout_out !== 1'b0) begin bad++; $display("FAIL single_drop_timeout: got %b want %b", bus.timeout_out, 1'b0); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    logic [7:0] exp_grant;
    apply_reset();
    bus.req_in = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_idx   = k[2:0];
      exp_grant = 8'd1 << exp_idx;
      tick();
      total++; if (bus.grant_valid_out !== 1'b1) begin bad++; $display("FAIL rot_valid[%0d]: got %b want %b", k, bus.grant_valid_out, 1'b1); end
      total++; if (bus.grant_idx_out !== exp_idx) begin bad++; $display("FAIL rot_idx[%0d]: got %0d want %0d", k, bus.grant_idx_out, exp_idx); end
      total++; if (bus.grant_out !== exp_grant) begin bad++; $display("FAIL rot_grant[%0d]: got %h want %h", k, bus.grant_out, exp_grant); end
      bus.done_in = 1'b1;
      tick();
      bus.done_in = 1'b0;
      total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL rot_idle[%0d]: got %b want %b", k, bus.grant_valid_out, 1'b0); end
      total++; if (bus.grant_out !== 8'h00) begin bad++; $display("FAIL rot_idle_grant[%0d]: got %h want %h", k, bus.grant_out, 8'h00); end
    end
  endtask

  task automatic test_wrap();
    bus.req_in = 8'h40;
    tick();
    total++; if (bus.grant_idx_out !== 3'd6) begin bad++; $display("FAIL wrap_first6: got %0d want %0d", bus.grant_idx_out, 6); end
    bus.req_in  = 8'h41;
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL wrap_rel6: got %b want %b", bus.grant_valid_out, 1'b0); end
    tick();
    total++; if (bus.grant_idx_out !== 3'd0) begin bad++; $display("FAIL wrap_to0: got %0d want %0d", bus.grant_idx_out, 0); end
    total++; if (bus.grant_out !== 8'h01) begin bad++; $display("FAIL wrap_to0_grant: got %h want %h", bus.grant_out, 8'h01); end
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL wrap_rel0: got %b want %b", bus.grant_valid_out, 1'b0); end
    tick();
    total++; if (bus.grant_idx_out !== 3'd6) begin bad++; $display("FAIL wrap_to6: got %0d want %0d", bus.grant_idx_out, 6); end
    total++; if (bus.grant_out !== 8'h40) begin bad++; $display("FAIL wrap_to6_grant: got %h want %h", bus.grant_out, 8'h40); end
    bus.req_in = 8'h00;
    tick();
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL drop_valid: got %b want %b", bus.grant_valid_out, 1'b0); end
    total++; if (bus.timeout_out !== 1'b0) begin bad++; $display("FAIL drop_timeout: got %b want %b", bus.timeout_out, 1'b0); end
  endtask

  task automatic test_timeout();
    bus.req_in  = 8'h02;
    bus.done_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (bus.grant_valid_out !== 1'b1) begin bad++; $display("FAIL tmo_hold_valid[%0d]: got %b want %b", c, bus.grant_valid_out, 1'b1); end
      total++; if (bus.grant_idx_out !== 3'd1) begin bad++; $display("FAIL tmo_hold_idx[%0d]: got %0d want %0d", c, bus.grant_idx_out, 1); end
      total++; if (bus.timeout_out !== 1'b0) begin bad++; $display("FAIL tmo_hold_pulse[%0d]: got %b want %b", c, bus.timeout_out, 1'b0); end
    end
    tick();
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL tmo_release_valid: got %b want %b", bus.grant_valid_out, 1'b0); end
    total++; if (bus.timeout_out !== 1'b1) begin bad++; $display("FAIL tmo_pulse: got %b want %b", bus.timeout_out, 1'b1); end
    tick();
    total++; if (bus.grant_valid_out !== 1'b1) begin bad++; $display("FAIL tmo_regrant_valid: got %b want %b", bus.grant_valid_out, 1'b1); end
    total++; if (bus.grant_idx_out !== 3'd1) begin bad++; $display("FAIL tmo_regrant_idx: got %0d want %0d", bus.grant_idx_out, 1); end
    total++; if (bus.timeout_out !== 1'b0) begin bad++; $display("FAIL tmo_pulse_width: got %b want %b", bus.timeout_out, 1'b0); end
  endtask

  // Continues from the re-grant left by test_timeout (counter at 0).
  task automatic test_simultaneous();
    tick();
    tick();
    tick();
    total++; if (bus.grant_valid_out !== 1'b1) begin bad++; $display("FAIL simul_still_held: got %b want %b", bus.grant_valid_out, 1'b1); end
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    bus.req_in  = 8'h00;
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL simul_valid: got %b want %b", bus.grant_valid_out, 1'b0); end
    total++; if (bus.timeout_out !== 1'b0) begin bad++; $display("FAIL simul_timeout: got %b want %b", bus.timeout_out, 1'b0); end
    tick();
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL idle_done_ignored: got %b want %b", bus.grant_valid_out, 1'b0); end
  endtask

  task automatic test_reset_mid_grant();
    bus.req_in = 8'h20;
    tick();
    total++; if (bus.grant_idx_out !== 3'd5) begin bad++; $display("FAIL midrst_pre_idx: got %0d want %0d", bus.grant_idx_out, 5); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.grant_out !== 8'h00) begin bad++; $display("FAIL midrst_grant: got %h want %h", bus.grant_out, 8'h00); end
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want %b", bus.grant_valid_out, 1'b0); end
    total++; if (bus.grant_idx_out !== 3'd0) begin bad++; $display("FAIL midrst_idx: got %0d want %0d", bus.grant_idx_out, 0); end
    bus.req_in = 8'hA0;
    tick();
    total++; if (bus.grant_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_held: got %b want %b", bus.grant_valid_out, 1'b0); end
    rst = 1'b0;
    tick();
    total++; if (bus.grant_idx_out !== 3'd5) begin bad++; $display("FAIL postrst_idx: got %0d want %0d", bus.grant_idx_out, 5); end
    total++; if (bus.grant_out !== 8'h20) begin bad++; $display("FAIL postrst_grant: got %h want %h", bus.grant_out, 8'h20); end
    total++; if (bus.grant_valid_out !== 1'b1) begin bad++; $display("FAIL postrst_valid: got %b want %b", bus.grant_valid_out, 1'b1); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
